// File: rtl/pc_gen_unit.sv
// PC generator: holds the architectural PC and resolves sequential, branch, jump, jump-register and
// return redirects in one cycle. Define PC_GEN_UNIT_RAS_EN to include the return-address stack.
module pc_gen_unit #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       IMM_W      = 16,
  parameter int unsigned       JIMM_W     = 26,
  parameter int unsigned       JUMP_SHIFT = 2,
  parameter int unsigned       PC_INC     = 1,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int unsigned       RAS_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              jump,
  input  logic              jump_reg,
  input  logic              call,
  input  logic              ret,
  input  logic [2:0]        branch_op,
  input  logic              zero,
  input  logic              neg,
  input  logic [IMM_W-1:0]  imm,
  input  logic [JIMM_W-1:0] jimm,
  input  logic [ADDR_W-1:0] jr_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_src,
  output logic [ADDR_W-1:0] target_address,
  output logic              ras_ovf,
  output logic              ras_unf
);

  localparam int unsigned JW = JIMM_W + JUMP_SHIFT;
  // Bits of the current PC that survive a direct jump (region bits above the immediate).
  localparam logic [ADDR_W-1:0] JHiMask =
      (JW >= ADDR_W) ? '0 : ~((ADDR_W'(1) << JW) - ADDR_W'(1));

  typedef enum logic [2:0] {
    BrNone = 3'd0,
    BrEq   = 3'd1,
    BrNe   = 3'd2,
    BrLt   = 3'd3,
    BrGe   = 3'd4
  } br_op_e;

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] seq;
  logic [ADDR_W-1:0] btgt;
  logic [ADDR_W-1:0] jtgt;
  logic [ADDR_W-1:0] ret_tgt;
  logic              br_taken;

  assign seq  = pc_q + ADDR_W'(PC_INC);
  assign btgt = seq + ADDR_W'($signed(imm));
  assign jtgt = (pc_q & JHiMask) | (ADDR_W'(jimm) << JUMP_SHIFT);

  always_comb begin
    br_taken = 1'b0;
    case (branch_op)
      BrEq:    br_taken = zero;
      BrNe:    br_taken = ~zero;
      BrLt:    br_taken = neg;
      BrGe:    br_taken = ~neg;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    pc_src         = 1'b1;
    target_address = '0;
    if (ret) begin
      target_address = ret_tgt;
    end else if (jump_reg) begin
      target_address = jr_addr;
    end else if (jump) begin
      target_address = jtgt;
    end else if (br_taken) begin
      target_address = btgt;
    end else begin
      pc_src = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (!stall) begin
      pc_q <= pc_src ? target_address : seq;
    end
  end

  assign pc = pc_q;

`ifdef PC_GEN_UNIT_RAS_EN
  localparam int unsigned PtrW = (RAS_DEPTH > 2) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PtrW:0] RasFull = (PtrW + 1)'(RAS_DEPTH);

  // Entries are deliberately left uninitialised; only pointer and count are reset.
  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PtrW-1:0]   ras_ptr_q, ras_ptr_d;
  logic [PtrW:0]     ras_cnt_q, ras_cnt_d;
  logic              ras_ovf_q, ras_ovf_d;
  logic              ras_unf_q, ras_unf_d;
  logic [PtrW-1:0]   top_idx;
  logic [PtrW-1:0]   wr_idx;
  logic              wr_en;
  logic              ras_empty;
  logic              push;
  logic              pop;

  assign top_idx   = ras_ptr_q - PtrW'(1);
  assign ras_empty = (ras_cnt_q == '0);
  assign ret_tgt   = ras_empty ? jr_addr : ras_mem[top_idx];
  assign push      = call & (jump | jump_reg);
  assign pop       = ret & ~ras_empty;

  always_comb begin
    ras_ptr_d = ras_ptr_q;
    ras_cnt_d = ras_cnt_q;
    ras_ovf_d = ras_ovf_q;
    ras_unf_d = ras_unf_q;
    wr_en     = 1'b0;
    wr_idx    = ras_ptr_q;
    if (!stall) begin
      if (ret && ras_empty) begin
        ras_unf_d = 1'b1;
      end
      if (push && pop) begin
        // Pop then push: the top slot is simply rewritten.
        wr_en  = 1'b1;
        wr_idx = top_idx;
      end else if (pop) begin
        ras_ptr_d = ras_ptr_q - PtrW'(1);
        ras_cnt_d = ras_cnt_q - (PtrW + 1)'(1);
      end else if (push) begin
        wr_en     = 1'b1;
        ras_ptr_d = ras_ptr_q + PtrW'(1);
        if (ras_cnt_q == RasFull) begin
          ras_ovf_d = 1'b1;
        end else begin
          ras_cnt_d = ras_cnt_q + (PtrW + 1)'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
      ras_ovf_q <= 1'b0;
      ras_unf_q <= 1'b0;
    end else begin
      ras_ptr_q <= ras_ptr_d;
      ras_cnt_q <= ras_cnt_d;
      ras_ovf_q <= ras_ovf_d;
      ras_unf_q <= ras_unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      ras_mem[wr_idx] <= seq;
    end
  end

  assign ras_ovf = ras_ovf_q;
  assign ras_unf = ras_unf_q;
`else
  // Without the stack a return is just a register jump and call is ignored.
  logic unused_call;
  assign unused_call = call;
  assign ret_tgt     = jr_addr;
  assign ras_ovf     = 1'b0;
  assign ras_unf     = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed self-checking bench for pc_gen_unit; RAS cases are selected by PC_GEN_UNIT_RAS_EN.
module tb_pc_gen_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        jump;
  logic        jump_reg;
  logic        call;
  logic        ret;
  logic [2:0]  branch_op;
  logic        zero;
  logic        neg;
  logic [15:0] imm;
  logic [25:0] jimm;
  logic [31:0] jr_addr;
  logic [31:0] pc;
  logic        pc_src;
  logic [31:0] target_address;
  logic        ras_ovf;
  logic        ras_unf;

  int n_checks = 0;
  int n_pass   = 0;

  pc_gen_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .jump           (jump),
    .jump_reg       (jump_reg),
    .call           (call),
    .ret            (ret),
    .branch_op      (branch_op),
    .zero           (zero),
    .neg            (neg),
    .imm            (imm),
    .jimm           (jimm),
    .jr_addr        (jr_addr),
    .pc             (pc),
    .pc_src         (pc_src),
    .target_address (target_address),
    .ras_ovf        (ras_ovf),
    .ras_unf        (ras_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; jump = 0; jump_reg = 0; call = 0; ret = 0;
    branch_op = 0; zero = 0; neg = 0; imm = 0; jimm = 0; jr_addr = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    #2;
    rst_n = 1;
    step();
  endtask

  task automatic set_pc(input logic [31:0] v);
    jump_reg = 1; jr_addr = v;
    step();
    jump_reg = 0; jr_addr = 0;
    #1;
  endtask

`ifdef PC_GEN_UNIT_RAS_EN
  logic [31:0] pop_exp [4];
`endif

  initial begin
    clear_inputs();
    rst_n = 0;
    #3;
    check("reset_pc", pc, 32'h0);
    check("reset_ovf", 32'(ras_ovf), 32'h0);
    check("reset_unf", 32'(ras_unf), 32'h0);
    step();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("seq_pc_src", 32'(pc_src), 32'h0);
      check("seq_target", target_address, 32'h0);
      step();
    end
    check("seq_pc3", pc, 32'h3);

    // Branch eq taken, backwards offset
    set_pc(32'h10);
    branch_op = 3'd1; zero = 1; imm = 16'hFFFE;
    #1;
    check("beq_src", 32'(pc_src), 32'h1);
    check("beq_tgt", target_address, 32'h0F);
    step();
    check("beq_pc", pc, 32'h0F);
    clear_inputs();

    set_pc(32'h10);
    branch_op = 3'd1; zero = 0; imm = 16'hFFFE;
    #1;
    check("beq_nt_src", 32'(pc_src), 32'h0);
    check("beq_nt_tgt", target_address, 32'h0);
    step();
    check("beq_nt_pc", pc, 32'h11);
    clear_inputs();

    set_pc(32'h10);
    branch_op = 3'd4; neg = 0; imm = 16'h4;
    #1;
    check("bge_tgt", target_address, 32'h15);
    step();
    check("bge_pc", pc, 32'h15);
    clear_inputs();

    // lt with neg clear and unused opcode 6 with flags set must not branch
    branch_op = 3'd3; neg = 0; imm = 16'h40;
    #1;
    check("blt_nt_src", 32'(pc_src), 32'h0);
    branch_op = 3'd6; neg = 1; zero = 1;
    #1;
    check("bop6_src", 32'(pc_src), 32'h0);
    branch_op = 3'd2; zero = 0;
    #1;
    check("bne_tgt", target_address, 32'h56);
    clear_inputs();

    // Jump beats branch; stall holds PC but leaves the target visible
    set_pc(32'hA000_0004);
    jump = 1; branch_op = 3'd1; zero = 1; imm = 16'h8; jimm = 26'h10;
    #1;
    check("jmp_tgt", target_address, 32'hA000_0040);
    stall = 1;
    step();
    check("stall_pc1", pc, 32'hA000_0004);
    step();
    check("stall_pc2", pc, 32'hA000_0004);
    check("stall_tgt", target_address, 32'hA000_0040);
    stall = 0;
    step();
    check("jmp_pc", pc, 32'hA000_0040);
    jump_reg = 1; jr_addr = 32'h1234;
    #1;
    check("jr_over_jmp", target_address, 32'h1234);
    clear_inputs();

    // Sequential wrap from all-ones
    set_pc(32'hFFFF_FFFF);
    step();
    check("wrap_pc", pc, 32'h0);

`ifdef PC_GEN_UNIT_RAS_EN
    do_reset();
    set_pc(32'h20);
    call = 1; jump = 1; jimm = 26'h40;
    step();
    clear_inputs();
    check("call_pc", pc, 32'h100);
    ret = 1; jr_addr = 32'h999;
    #1;
    check("ret_tgt", target_address, 32'h21);
    step();
    check("ret_pc", pc, 32'h21);
    clear_inputs();

    // Five nested calls from 0x21 push 0x22,0x101,0x201,0x301,0x401; the fifth overwrites 0x22
    for (int i = 0; i < 5; i++) begin
      call = 1; jump_reg = 1; jr_addr = 32'((i + 1) * 32'h100);
      step();
      if (i == 3) check("ovf_at4", 32'(ras_ovf), 32'h0);
    end
    check("ovf_at5", 32'(ras_ovf), 32'h1);
    clear_inputs();
    pop_exp = '{32'h401, 32'h301, 32'h201, 32'h101};
    ret = 1; jr_addr = 32'hBEEF;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("pop%0d", i), target_address, pop_exp[i]);
      step();
    end
    check("unf_before", 32'(ras_unf), 32'h0);
    check("pop_empty", target_address, 32'hBEEF);
    step();
    check("unf_after", 32'(ras_unf), 32'h1);
    clear_inputs();

    // Simultaneous ret and call rewrites the top entry
    do_reset();
    set_pc(32'h2F);
    call = 1; jump_reg = 1; jr_addr = 32'h50;
    step();
    ret = 1; call = 1; jump_reg = 1; jr_addr = 32'h77;
    #1;
    check("rc_tgt", target_address, 32'h30);
    step();
    check("rc_pc", pc, 32'h30);
    clear_inputs();
    ret = 1; jr_addr = 32'h88;
    #1;
    check("rc_top", target_address, 32'h51);
    step();
    check("rc_unf_hold", 32'(ras_unf), 32'h0);
    check("rc_empty", target_address, 32'h88);
    step();
    check("rc_unf", 32'(ras_unf), 32'h1);
    clear_inputs();
`else
    do_reset();
    ret = 1; jr_addr = 32'h77;
    #1;
    check("ret_src", 32'(pc_src), 32'h1);
    check("ret_tgt", target_address, 32'h77);
    step();
    check("ret_pc", pc, 32'h77);
    clear_inputs();
    call = 1;
    #1;
    check("call_src", 32'(pc_src), 32'h0);
    step();
    check("call_pc", pc, 32'h78);
    jump = 1; jimm = 26'h40;
    step();
    clear_inputs();
    ret = 1; jr_addr = 32'h66;
    #1;
    check("ret_no_ras", target_address, 32'h66);
    step();
    clear_inputs();
    check("flag_ovf", 32'(ras_ovf), 32'h0);
    check("flag_unf", 32'(ras_unf), 32'h0);
`endif

    // Async reset while stalled takes effect without a clock edge
    set_pc(32'h55);
    stall = 1;
    #2;
    rst_n = 0;
    #1;
    check("async_rst_pc", pc, 32'h0);
    check("async_rst_unf", 32'(ras_unf), 32'h0);
    #2;
    rst_n = 1;
    clear_inputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_gen_unit.md
Name: pc_gen_unit

Overview:
- Sequential successor to the combinational next-PC logic.
- Owns the architectural PC register and resolves sequential, branch, jump, jump-register and return redirects in one cycle.
- Generalised in address/immediate width and branch condition set.
- Optionally includes a return-address stack (RAS) for call/return.
- Sits between decode/ALU flags and the instruction-memory address port.

Parameters:
- ADDR_W, 32, PC and address width
- IMM_W, 16, branch offset width, sign-extended to ADDR_W
- JIMM_W, 26, jump immediate width
- JUMP_SHIFT, 2, zero bits appended below the jump immediate
- PC_INC, 1, sequential increment; branch base is pc+PC_INC
- RESET_PC, 0, PC value after reset
- RAS_DEPTH, 4, RAS entries (power of 2, ≥2); used only with the RAS feature

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  1 = hold PC and all state
- jump  in  1  direct jump using jimm
- jump_reg  in  1  jump to jr_addr
- call  in  1  push return address; qualifies jump or jump_reg
- ret  in  1  return (pop RAS)
- branch_op  in  3  0 none, 1 eq, 2 ne, 3 lt, 4 ge, 5-7 none
- zero  in  1  ALU zero flag
- neg  in  1  ALU negative flag
- imm  in  IMM_W  branch offset
- jimm  in  JIMM_W  jump immediate
- jr_addr  in  ADDR_W  register jump/return fallback address
- pc  out  ADDR_W  current PC (registered)
- pc_src  out  1  redirect this cycle (combinational)
- target_address  out  ADDR_W  redirect target; 0 when pc_src=0 (combinational)
- ras_ovf  out  1  sticky: push while RAS full
- ras_unf  out  1  sticky: pop while RAS empty

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, RAS pointer=0, RAS count=0, ras_ovf=0, ras_unf=0.
  - RAS entries are not cleared.
  - Applies immediately mid-operation; no pending redirect survives.
- Arithmetic:
  - seq = pc+PC_INC, modulo 2^ADDR_W; wrap from all-ones is silent.
  - btgt = seq + sext(imm), modulo.
  - jtgt = {pc[ADDR_W-1 : JIMM_W+JUMP_SHIFT], jimm, JUMP_SHIFT×0}.
- Branch taken conditions:
  - eq: zero=1
  - ne: zero=0
  - lt: neg=1
  - ge: neg=0
- Redirect priority, highest first:
  - ret
  - jump_reg
  - jump
  - branch taken
  - none
- Redirect targets:
  - ret: RAS top, or jr_addr if the RAS is empty.
  - jump_reg: jr_addr.
  - jump: jtgt.
  - branch taken: btgt.
  - pc_src=1 for any redirect; otherwise pc_src=0 and target_address=0.
- PC update at posedge with stall=0: pc ← target_address if pc_src, else seq.
- Stall:
  - stall=1 freezes pc, the RAS and the flags.
  - pc_src and target_address still reflect current inputs.
- RAS push:
  - When call=1 and (jump or jump_reg), push seq.
  - call without a jump is ignored.
  - Push when full overwrites the oldest entry (circular); count stays RAS_DEPTH; ras_ovf←1.
- RAS pop:
  - When ret=1 and count>0, pop; the top becomes the target.
  - When ret=1 and count=0, no state change except ras_unf←1; target is jr_addr.
- ret with call in the same cycle: pop and push both apply, so the top entry is replaced by seq and count is unchanged. An empty RAS still sets ras_unf, and the push then proceeds.
- Sticky flags clear only on reset.
- Latency: target is visible combinationally in the same cycle; pc reflects it after one clock edge.

Optional Feature:
- Macro: PC_GEN_UNIT_RAS_EN.
- Defined: RAS behaves as described.
- Undefined:
  - No RAS storage.
  - ret behaves exactly like jump_reg, targeting jr_addr.
  - call has no effect.
  - ras_ovf and ras_unf are tied to 0.

Test Plan:
- Reset and sequential: rst_n low → pc=0. Release, 3 unstalled clocks → pc=3; pc_src=0 and target_address=0 throughout.
- Branch: pc=0x10, branch_op=1, zero=1, imm=0xFFFE → pc_src=1, target=0x0F, next pc=0x0F. Same with zero=0 → pc=0x11. branch_op=4 with neg=0, imm=4 → pc=0x15.
- Jump priority and stall: pc=0xA0000004, jump=1, branch_op=1, zero=1, jimm=0x10 → target=0xA0000040. With stall=1 for 2 clocks, pc holds, then updates on the first unstalled edge.
- Call/return (macro defined): call+jump from pc=0x20 pushes 0x21 → later ret → target 0x21. Five nested calls with RAS_DEPTH=4 → ras_ovf=1; five rets return the last four addresses, then jr_addr with ras_unf=1.
- Call and ret together: RAS holds 0x30; ret+call+jump_reg, pc=0x50 → target=0x30; top becomes 0x51; count unchanged.
- Macro undefined: ret=1, jr_addr=0x77 → pc=0x77; call has no effect; flags stay 0. Async reset asserted mid-stall → pc=RESET_PC immediately, without a clock edge.
